phase_sequencer: RTL and testbench

Parametrised multi-cycle phase controller for the multicycle CPU datapath. It generates the fetch/decode/exec/mem/write-back phase index that the pipeline stages key off, for any phase count. Beyond a free-running phase counter it adds:
- memory wait-states;
- external stall;
- halt on instruction;
- run/single-step debug control;
- retired-instruction counting.

---
 rtl/phase_sequencer_pkg.sv | 28 ++
 rtl/phase_sequencer_if.sv | 52 +++++
 rtl/phase_sequencer_mem_wait_timer.sv | 47 ++++
 rtl/phase_sequencer.sv | 144 ++++++++++++++
 tb/tb_phase_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_sequencer_pkg.sv
// +-----------------------------------------------------------------------+
// | phase_seq_pkg : mode encoding, default phase indices, timer sizing    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package phase_seq_pkg;

   typedef enum logic [1:0] {
      MODE_HALT = 2'd0,
      MODE_RUN  = 2'd1,
      MODE_STEP = 2'd2
   } mode_e;

   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_EXEC   = 2;
   localparam int P_MEM    = 3;
   localparam int P_WB     = 4;

   // Wait counter must hold WAIT_CYCLES itself; never narrower than one bit.
   function automatic int wait_cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/phase_sequencer_if.sv
// +-----------------------------------------------------------------------+
// | phase_seq_if : control/status bundle of the phase sequencer.          |
// | PHASE_SEQ_PERF_EN adds the cycle/stall performance counters.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

interface phase_seq_if #(
   parameter int NUM_PHASES = 5,
   parameter int PHASE_W    = 3,
   parameter int CNT_W      = 16
);
   logic                  run;
   logic                  step;
   logic                  halt_req;
   logic                  mem_access;
   logic                  ext_stall;
   logic [PHASE_W-1:0]    state;
   logic [NUM_PHASES-1:0] phase_onehot;
   logic                  phase_en;
   logic                  instr_done;
   logic                  halted;
   logic [CNT_W-1:0]      instr_count;
`ifdef PHASE_SEQ_PERF_EN
   logic [31:0]           cycle_count;
   logic [31:0]           stall_count;

   modport master (
      output run, step, halt_req, mem_access, ext_stall,
      input  state, phase_onehot, phase_en, instr_done, halted, instr_count,
      input  cycle_count, stall_count
   );

   modport slave (
      input  run, step, halt_req, mem_access, ext_stall,
      output state, phase_onehot, phase_en, instr_done, halted, instr_count,
      output cycle_count, stall_count
   );
`else
   modport master (
      output run, step, halt_req, mem_access, ext_stall,
      input  state, phase_onehot, phase_en, instr_done, halted, instr_count
   );

   modport slave (
      input  run, step, halt_req, mem_access, ext_stall,
      output state, phase_onehot, phase_en, instr_done, halted, instr_count
   );
`endif
endinterface

`default_nettype wire

// File: rtl/phase_sequencer_mem_wait_timer.sv
// +-----------------------------------------------------------------------+
// | mem_wait_timer : counts memory wait-states of the memory phase.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module mem_wait_timer
   import phase_seq_pkg::*;
#(
   parameter int WAIT_CYCLES = 2
) (
   input  wire logic clock,
   input  wire logic reset,
   input  wire logic enable,
   input  wire logic hold,
   input  wire logic clear,
   output logic      done
);

   localparam int CW = wait_cnt_width(WAIT_CYCLES);

   logic [CW-1:0] wait_cnt_q;
   logic [CW-1:0] wait_cnt_d;

   // Clear has priority so a phase advance never leaves a stale count behind.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clear) begin
         wait_cnt_d = '0;
      end else if (enable && !hold) begin
         wait_cnt_d = wait_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign done = (wait_cnt_q == CW'(WAIT_CYCLES));

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// +-----------------------------------------------------------------------+
// | phase_sequencer : multicycle CPU phase controller with wait-states,   |
// | stall, halt, run/step debug and retired-instruction counting.         |
// | PHASE_SEQ_PERF_EN adds cycle_count / stall_count.                     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module phase_sequencer
   import phase_seq_pkg::*;
#(
   parameter int NUM_PHASES  = P_WB + 1,
   parameter int PHASE_W     = 3,
   parameter int MEM_PHASE   = P_MEM,
   parameter int WAIT_CYCLES = 2,
   parameter int AUTO_RUN    = 1,
   parameter int CNT_W       = 16
) (
   input  wire logic  clock,
   input  wire logic  reset,
   phase_seq_if.slave sif
);

   localparam mode_e RESET_MODE = (AUTO_RUN != 0) ? MODE_RUN : MODE_HALT;

   mode_e                 mode_q;
   mode_e                 mode_d;
   logic [PHASE_W-1:0]    state_q;
   logic [PHASE_W-1:0]    state_d;
   logic [CNT_W-1:0]      instr_count_q;
   logic [CNT_W-1:0]      instr_count_d;
   logic                  halted_q;
   logic                  halted_d;

   logic                  active;
   logic                  wait_done;
   logic                  mem_wait;
   logic                  phase_en;
   logic                  last_phase;
   logic                  instr_done;
   logic                  wait_clear;
   logic [NUM_PHASES-1:0] onehot;

   assign active     = (mode_q != MODE_HALT);
   assign mem_wait   = active && (state_q == PHASE_W'(MEM_PHASE)) && sif.mem_access && !wait_done;
   assign phase_en   = active && !sif.ext_stall && !mem_wait;
   assign last_phase = (state_q == PHASE_W'(NUM_PHASES - 1));
   assign instr_done = phase_en && last_phase;
   assign wait_clear = phase_en || !sif.mem_access;

   mem_wait_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_mem_wait_timer (
      .clock  (clock),
      .reset  (reset),
      .enable (mem_wait),
      .hold   (sif.ext_stall),
      .clear  (wait_clear),
      .done   (wait_done)
   );

   // halt_req only matters on the completing last phase; a stall there blocks it.
   always_comb begin
      mode_d        = mode_q;
      state_d       = state_q;
      instr_count_d = instr_count_q;
      if (phase_en) begin
         state_d = last_phase ? '0 : state_q + PHASE_W'(1);
      end
      if (instr_done) begin
         instr_count_d = instr_count_q + CNT_W'(1);
         if (sif.halt_req || (mode_q == MODE_STEP)) begin
            mode_d = MODE_HALT;
         end
      end
      if ((mode_q == MODE_HALT) && !sif.ext_stall) begin
         if (sif.run) begin
            mode_d = MODE_RUN;
         end else if (sif.step) begin
            mode_d = MODE_STEP;
         end
      end
      halted_d = (mode_d == MODE_HALT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q        <= RESET_MODE;
         state_q       <= '0;
         instr_count_q <= '0;
         halted_q      <= (RESET_MODE == MODE_HALT);
      end else begin
         mode_q        <= mode_d;
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
         halted_q      <= halted_d;
      end
   end

   for (genvar i = 0; i < NUM_PHASES; i++) begin : g_onehot
      assign onehot[i] = !halted_q && (state_q == PHASE_W'(i));
   end

   assign sif.state        = state_q;
   assign sif.phase_onehot = onehot;
   assign sif.phase_en     = phase_en;
   assign sif.instr_done   = instr_done;
   assign sif.halted       = halted_q;
   assign sif.instr_count  = instr_count_q;

`ifdef PHASE_SEQ_PERF_EN
   logic [31:0] cycle_count_q;
   logic [31:0] cycle_count_d;
   logic [31:0] stall_count_q;
   logic [31:0] stall_count_d;

   always_comb begin
      cycle_count_d = cycle_count_q;
      stall_count_d = stall_count_q;
      if (active) begin
         cycle_count_d = cycle_count_q + 32'd1;
         if (!phase_en) begin
            stall_count_d = stall_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cycle_count_q <= '0;
         stall_count_q <= '0;
      end else begin
         cycle_count_q <= cycle_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign sif.cycle_count = cycle_count_q;
   assign sif.stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// +-----------------------------------------------------------------------+
// | tb_phase_sequencer : scoreboard bench; expected completed phases are  |
// | queued by the stimulus and popped by a monitor on every phase_en.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_phase_sequencer;

   typedef struct {
      int st;
      bit done;
      int cnt;
      int gap;   // cycles since previous completed phase; 0 = not checked
   } exp_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   exp_t exp_q[$];
   int   gap;
`ifdef PHASE_SEQ_PERF_EN
   logic [31:0] cyc0;
   logic [31:0] stl0;
`endif

   phase_seq_if #(.NUM_PHASES(5), .PHASE_W(3), .CNT_W(16)) sif ();
   phase_seq_if #(.NUM_PHASES(5), .PHASE_W(3), .CNT_W(16)) sif2 ();

   phase_sequencer #(
      .NUM_PHASES(5), .PHASE_W(3), .MEM_PHASE(3), .WAIT_CYCLES(2), .AUTO_RUN(1), .CNT_W(16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .sif   (sif)
   );

   phase_sequencer #(
      .NUM_PHASES(5), .PHASE_W(3), .MEM_PHASE(3), .WAIT_CYCLES(2), .AUTO_RUN(0), .CNT_W(16)
   ) dut_halt (
      .clock (clock),
      .reset (reset),
      .sif   (sif2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_one(int st, bit done, int cnt, int g);
      exp_t e;
      e.st = st; e.done = done; e.cnt = cnt; e.gap = g;
      exp_q.push_back(e);
   endtask

   task automatic push_instr(int cnt, int gap0, int memgap);
      push_one(0, 1'b0, cnt, gap0);
      push_one(1, 1'b0, cnt, 1);
      push_one(2, 1'b0, cnt, 1);
      push_one(3, 1'b0, cnt, memgap);
      push_one(4, 1'b1, cnt, 1);
   endtask

   // Monitor: every completed phase must match the head of the queue.
   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         gap = 0;
      end else begin
         gap++;
         if (sif.phase_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_phase_en_state", {29'd0, sif.state}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("sb_state", {29'd0, sif.state}, e.st);
               chk("sb_instr_done", {31'd0, sif.instr_done}, {31'd0, e.done});
               chk("sb_instr_count", {16'd0, sif.instr_count}, e.cnt);
               if (e.gap != 0) chk("sb_phase_gap", gap, e.gap);
            end
            gap = 0;
         end
      end
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; gap = 0;
      reset = 1'b0;
      sif.run = 0;  sif.step = 0;  sif.halt_req = 0;  sif.mem_access = 0;  sif.ext_stall = 0;
      sif2.run = 0; sif2.step = 0; sif2.halt_req = 0; sif2.mem_access = 0; sif2.ext_stall = 0;
      #2 reset = 1'b1;
      repeat (3) tick();

      // Reset state of both builds
      chk("rst_state", {29'd0, sif.state}, 0);
      chk("rst_halted", {31'd0, sif.halted}, 0);
      chk("rst_count", {16'd0, sif.instr_count}, 0);
      chk("rst_onehot", {27'd0, sif.phase_onehot}, 1);
      chk("rst_halted_autorun0", {31'd0, sif2.halted}, 1);
      chk("rst_onehot_autorun0", {27'd0, sif2.phase_onehot}, 0);
`ifdef PHASE_SEQ_PERF_EN
      chk("rst_cycle_count", sif.cycle_count, 0);
      chk("rst_stall_count", sif.stall_count, 0);
`endif

      // Free run: three 5-cycle instructions
      reset = 1'b0;
      push_instr(0, 1, 1);
      push_instr(1, 1, 1);
      push_instr(2, 1, 1);
      repeat (15) tick();
      chk("free_run_count", {16'd0, sif.instr_count}, 3);
      chk("free_run_state", {29'd0, sif.state}, 0);

      // Memory wait: state 3 lasts 3 cycles, instruction 7 cycles
      sif.mem_access = 1;
      push_instr(3, 1, 3);
      repeat (7) tick();
      chk("mem_instr_count", {16'd0, sif.instr_count}, 4);
      chk("mem_instr_state", {29'd0, sif.state}, 0);
      sif.mem_access = 0;

      // Halt sampling: ignored at state 2, taken at state 4
      push_instr(4, 1, 1);
      tick(); tick();
      chk("halt_probe_state2", {29'd0, sif.state}, 2);
      sif.halt_req = 1;
      tick();
      sif.halt_req = 0;
      chk("halt_ignored_state3", {29'd0, sif.state}, 3);
      tick();
      sif.halt_req = 1;
      tick();
      sif.halt_req = 0;
      chk("halt_halted", {31'd0, sif.halted}, 1);
      chk("halt_onehot", {27'd0, sif.phase_onehot}, 0);
      chk("halt_count", {16'd0, sif.instr_count}, 5);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("halt_hold_state", {29'd0, sif.state}, 0);
         chk("halt_hold_halted", {31'd0, sif.halted}, 1);
      end

      // Single step
      push_instr(5, 0, 1);
      sif.step = 1;
      tick();
      sif.step = 0;
      chk("step_running", {31'd0, sif.halted}, 0);
      repeat (5) tick();
      chk("step_halted_again", {31'd0, sif.halted}, 1);
      chk("step_count", {16'd0, sif.instr_count}, 6);
      tick(); tick();
      chk("step_stays_halted", {31'd0, sif.halted}, 1);

      // run and step together: RUN wins
      push_instr(6, 0, 1);
      push_instr(7, 1, 1);
      sif.run = 1; sif.step = 1;
      tick();
      sif.run = 0; sif.step = 0;
      repeat (10) tick();
      chk("runstep_not_halted", {31'd0, sif.halted}, 0);
      chk("runstep_count", {16'd0, sif.instr_count}, 8);

      // Stall during memory wait (wait_cnt=1): memory phase spans 7 cycles
      sif.mem_access = 1;
      push_instr(8, 1, 7);
`ifdef PHASE_SEQ_PERF_EN
      cyc0 = sif.cycle_count;
      stl0 = sif.stall_count;
`endif
      tick(); tick(); tick();
      chk("stall_enter_state3", {29'd0, sif.state}, 3);
      tick();
      sif.ext_stall = 1;
      for (int i = 0; i < 4; i++) begin
         chk("stall_frozen_state", {29'd0, sif.state}, 3);
         if (i < 3) tick();
      end
      tick();
      sif.ext_stall = 0;
      tick(); tick(); tick();
      chk("stall_instr_count", {16'd0, sif.instr_count}, 9);
`ifdef PHASE_SEQ_PERF_EN
      chk("perf_stall_delta", sif.stall_count - stl0, 6);
      chk("perf_cycle_delta", sif.cycle_count - cyc0, 11);
`endif

      // Reset mid-wait: state=3, wait_cnt=1
      push_one(0, 1'b0, 9, 1);
      push_one(1, 1'b0, 9, 1);
      push_one(2, 1'b0, 9, 1);
      tick(); tick(); tick(); tick();
      chk("pre_reset_state3", {29'd0, sif.state}, 3);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_state", {29'd0, sif.state}, 0);
      chk("async_rst_count", {16'd0, sif.instr_count}, 0);
      chk("async_rst_halted", {31'd0, sif.halted}, 0);
      chk("async_rst_halted_autorun0", {31'd0, sif2.halted}, 1);
      sif.ext_stall = 1;
      sif.mem_access = 0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("autorun0_idle_state", {29'd0, sif2.state}, 0);
         chk("autorun0_idle_halted", {31'd0, sif2.halted}, 1);
      end
      sif2.run = 1;
      tick();
      sif2.run = 0;
      chk("autorun0_run_halted", {31'd0, sif2.halted}, 0);
      chk("autorun0_run_phase_en", {31'd0, sif2.phase_en}, 1);
      tick();
      chk("autorun0_advance", {29'd0, sif2.state}, 1);

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
